// File: rtl/ps2_kbd_pkg.sv
// Shared constants, event layout and decoder state encoding for the PS/2
// Set-2 scan-code decoder.
package ps2_kbd_pkg;

  localparam logic [7:0] PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PREFIX_BRK   = 8'hF0;
  localparam logic [7:0] PREFIX_PAUSE = 8'hE1;

  localparam logic [7:0] ST_ERR0    = 8'h00;
  localparam logic [7:0] ST_BAT_OK  = 8'hAA;
  localparam logic [7:0] ST_ECHO    = 8'hEE;
  localparam logic [7:0] ST_ACK     = 8'hFA;
  localparam logic [7:0] ST_BAT_ERR = 8'hFC;
  localparam logic [7:0] ST_ERR1    = 8'hFF;

  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CTRL   = 8'h14;
  localparam logic [7:0] KEY_ALT    = 8'h11;
  localparam logic [7:0] KEY_CAPS   = 8'h58;

  // Event word: {brk, ext, code[7:0]}
  localparam int EVT_W        = 10;
  localparam int EVT_CODE_LSB = 0;
  localparam int EVT_EXT_BIT  = 8;
  localparam int EVT_BRK_BIT  = 9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } dec_state_e;

  function automatic logic is_status(input logic [7:0] b);
    return (b == ST_ERR0) || (b == ST_BAT_OK) || (b == ST_ECHO) ||
           (b == ST_ACK)  || (b == ST_BAT_ERR) || (b == ST_ERR1);
  endfunction

  function automatic logic [EVT_W-1:0] make_evt(input logic ext, input logic brk,
                                                input logic [7:0] code);
    logic [EVT_W-1:0] e;
    e = '0;
    e[EVT_CODE_LSB +: 8] = code;
    e[EVT_EXT_BIT]       = ext;
    e[EVT_BRK_BIT]       = brk;
    return e;
  endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Scan-code input and key-event output bundle of the decoder.
// valid/ready: the receive stage presents CODE while NEW_CODE is high (one byte per
// rising edge); an event transfers on any cycle where EVT_VALID and RD_EN are both 1.
interface ps2_scan_decoder_if;
  logic [7:0] CODE;
  logic       NEW_CODE;
  logic       RD_EN;
  logic [7:0] EVT_CODE;
  logic       EVT_EXT;
  logic       EVT_BRK;
  logic       EVT_VALID;

  modport slave (
    input  CODE, NEW_CODE, RD_EN,
    output EVT_CODE, EVT_EXT, EVT_BRK, EVT_VALID
  );

  modport master (
    output CODE, NEW_CODE, RD_EN,
    input  EVT_CODE, EVT_EXT, EVT_BRK, EVT_VALID
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO: head entry is visible whenever empty is low.
// A push into a full FIFO succeeds only if the head is popped in the same cycle.
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full,
  output logic         drop
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_en & (~full | do_pop);
  assign drop    = wr_en & full & ~do_pop;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Assembles Set-2 scan-code bytes (E0/F0/E1 prefixes) into key events, tracks
// modifier and Caps Lock state, and queues events for the application.
module ps2_scan_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PAUSE_SKIP = 7
) (
  input  logic                CLK,
  input  logic                RST,
  ps2_scan_decoder_if.slave   bus,
  output logic                FIFO_FULL,
  output logic                OVERFLOW,
  output logic                SHIFT,
  output logic                CTRL,
  output logic                ALT,
  output logic                CAPS_LOCK,
  output dec_state_e          dbg_state
);

  logic       s1_q, s2_q, s3_q;
  logic       accept;
  logic [7:0] byte_q, byte_d;
  logic       byte_vld_q, byte_vld_d;

  dec_state_e       state_q, state_d;
  logic [7:0]       skip_q, skip_d;
  logic             emit;
  logic [EVT_W-1:0] evt;
  logic             special;

  logic lshift_q, lshift_d, rshift_q, rshift_d;
  logic lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic lalt_q, lalt_d, ralt_q, ralt_d;
  logic caps_held_q, caps_held_d, caps_q, caps_d;
  logic shift_q, shift_d, ctrl_q, ctrl_d, alt_q, alt_d;
  logic overflow_q, overflow_d;

  logic             evt_make, evt_ext;
  logic [7:0]       evt_code;
  logic [EVT_W-1:0] head;
  logic             fifo_empty, fifo_full, fifo_drop;

  // NEW_CODE is a level from another clock domain; act only on its rising edge.
  assign accept  = s2_q & ~s3_q;
  assign special = is_status(byte_q) || (byte_q == PREFIX_EXT) ||
                   (byte_q == PREFIX_BRK) || (byte_q == PREFIX_PAUSE);

  always_comb begin
    byte_vld_d = accept;
    byte_d     = accept ? bus.CODE : byte_q;
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    evt     = '0;
    if (byte_vld_q) begin
      case (state_q)
        S_IDLE: begin
          if (byte_q == PREFIX_EXT) state_d = S_EXT;
          else if (byte_q == PREFIX_BRK) state_d = S_BRK;
          else if (byte_q == PREFIX_PAUSE) begin
            emit    = 1'b1;
            evt     = make_evt(1'b1, 1'b0, PREFIX_PAUSE);
            skip_d  = 8'(PAUSE_SKIP);
            state_d = S_PAUSE;
          end else if (!is_status(byte_q)) begin
            emit = 1'b1;
            evt  = make_evt(1'b0, 1'b0, byte_q);
          end
        end
        S_EXT: begin
          if (byte_q == PREFIX_BRK) state_d = S_EXT_BRK;
          else if (byte_q == PREFIX_EXT) state_d = S_EXT;
          else begin
            state_d = S_IDLE;
            if (!special) begin
              emit = 1'b1;
              evt  = make_evt(1'b1, 1'b0, byte_q);
            end
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          if (!special) begin
            emit = 1'b1;
            evt  = make_evt(1'b0, 1'b1, byte_q);
          end
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          if (!special) begin
            emit = 1'b1;
            evt  = make_evt(1'b1, 1'b1, byte_q);
          end
        end
        S_PAUSE: begin
          // The rest of the pause sequence carries no key information.
          skip_d = skip_q - 1'b1;
          if (skip_q <= 8'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign evt_make = ~evt[EVT_BRK_BIT];
  assign evt_ext  = evt[EVT_EXT_BIT];
  assign evt_code = evt[EVT_CODE_LSB +: 8];

  // Modifiers follow every decoded event, including ones the FIFO had to drop.
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    lalt_d      = lalt_q;
    ralt_d      = ralt_q;
    caps_held_d = caps_held_q;
    caps_d      = caps_q;
    if (emit) begin
      if (!evt_ext && evt_code == KEY_LSHIFT) lshift_d = evt_make;
      if (!evt_ext && evt_code == KEY_RSHIFT) rshift_d = evt_make;
      if (!evt_ext && evt_code == KEY_CTRL)   lctrl_d  = evt_make;
      if ( evt_ext && evt_code == KEY_CTRL)   rctrl_d  = evt_make;
      if (!evt_ext && evt_code == KEY_ALT)    lalt_d   = evt_make;
      if ( evt_ext && evt_code == KEY_ALT)    ralt_d   = evt_make;
      if (!evt_ext && evt_code == KEY_CAPS) begin
        if (evt_make && !caps_held_q) caps_d = ~caps_q;
        caps_held_d = evt_make;
      end
    end
    shift_d    = lshift_d | rshift_d;
    ctrl_d     = lctrl_d | rctrl_d;
    alt_d      = lalt_d | ralt_d;
    overflow_d = overflow_q | fifo_drop;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      state_q     <= S_IDLE;
      skip_q      <= '0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      lalt_q      <= 1'b0;
      ralt_q      <= 1'b0;
      caps_held_q <= 1'b0;
      caps_q      <= 1'b0;
      shift_q     <= 1'b0;
      ctrl_q      <= 1'b0;
      alt_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      s1_q        <= bus.NEW_CODE;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      byte_q      <= byte_d;
      byte_vld_q  <= byte_vld_d;
      state_q     <= state_d;
      skip_q      <= skip_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      lalt_q      <= lalt_d;
      ralt_q      <= ralt_d;
      caps_held_q <= caps_held_d;
      caps_q      <= caps_d;
      shift_q     <= shift_d;
      ctrl_q      <= ctrl_d;
      alt_q       <= alt_d;
      overflow_q  <= overflow_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .wr_en   (emit),
    .wr_data (evt),
    .rd_en   (bus.RD_EN),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .drop    (fifo_drop)
  );

  assign bus.EVT_CODE  = head[EVT_CODE_LSB +: 8];
  assign bus.EVT_EXT   = head[EVT_EXT_BIT];
  assign bus.EVT_BRK   = head[EVT_BRK_BIT];
  assign bus.EVT_VALID = ~fifo_empty;
  assign FIFO_FULL     = fifo_full;
  assign OVERFLOW      = overflow_q;
  assign SHIFT         = shift_q;
  assign CTRL          = ctrl_q;
  assign ALT           = alt_q;
  assign CAPS_LOCK     = caps_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: byte-stream reference model feeds an
// expected-event queue, a negedge monitor pops and compares delivered events.
module tb_ps2_scan_decoder;
  import ps2_kbd_pkg::*;

  localparam int DEPTH = 4;
  localparam int SKIP  = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_full, overflow, shift, ctrl, alt, caps_lock;
  dec_state_e dbg_state;

  ps2_scan_decoder_if bus();

  ps2_scan_decoder #(.FIFO_DEPTH(DEPTH), .PAUSE_SKIP(SKIP)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .bus       (bus),
    .FIFO_FULL (fifo_full),
    .OVERFLOW  (overflow),
    .SHIFT     (shift),
    .CTRL      (ctrl),
    .ALT       (alt),
    .CAPS_LOCK (caps_lock),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: prefix flags, pause skip count, set of held keys.
  bit         m_ext, m_brk, m_ovf, m_caps;
  int         m_skip, m_cnt;
  bit         held[int];
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;
  int         n_pass, n_total;
  logic [7:0] keys[10] = '{8'h1C, 8'h32, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h75, 8'h6B, 8'h21};
  logic [7:0] stats[6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFF};
  logic [7:0] pause_seq[8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit hk(input int k);
    return held.exists(k) ? held[k] : 1'b0;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_caps = 0; m_skip = 0; m_cnt = 0;
    held.delete();
    exp_q.delete();
  endtask

  task automatic m_emit(input bit ext, input bit brk, input logic [7:0] code, input bit pop_now);
    int key = (ext ? 256 : 0) + int'(code);
    if (m_cnt < DEPTH || pop_now) begin
      exp_q.push_back({brk, ext, code});
      m_cnt++;
    end else m_ovf = 1;
    if (brk) held[key] = 0;
    else begin
      if (key == 'h58 && !hk(key)) m_caps = !m_caps;
      held[key] = 1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit pop_now);
    bit is_stat = (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
                  (b == 8'hFA) || (b == 8'hFC) || (b == 8'hFF);
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    if (b == 8'hE1) begin
      if (!m_ext && !m_brk) begin
        m_emit(1, 0, 8'hE1, pop_now);
        m_skip = SKIP;
      end
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      if (m_brk) begin m_ext = 0; m_brk = 0; end
      else m_ext = 1;
    end else if (b == 8'hF0) begin
      if (m_brk) begin m_ext = 0; m_brk = 0; end
      else m_brk = 1;
    end else if (is_stat) begin
      m_ext = 0; m_brk = 0;
    end else begin
      m_emit(m_ext, m_brk, b, pop_now);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic check_flags();
    chk("shift", shift, hk('h12) | hk('h59));
    chk("ctrl", ctrl, hk('h14) | hk('h114));
    chk("alt", alt, hk('h11) | hk('h111));
    chk("caps_lock", caps_lock, m_caps);
    chk("fifo_full", fifo_full, m_cnt == DEPTH);
    chk("overflow", overflow, m_ovf);
  endtask

  // pop_now raises RD_EN exactly in the cycle the decoded event is written.
  task automatic send(input logic [7:0] b, input int hold, input bit pop_now);
    @(posedge clk); #2;
    bus.CODE = b;
    bus.NEW_CODE = 1'b1;
    model_byte(b, pop_now);
    if (pop_now) begin
      repeat (3) @(posedge clk);
      #2 bus.RD_EN = 1'b1;
      @(posedge clk);
      #2 bus.RD_EN = 1'b0;
      repeat (hold - 4) @(posedge clk);
    end else repeat (hold) @(posedge clk);
    #2;
    bus.NEW_CODE = 1'b0;
    bus.CODE = 8'($urandom);
    repeat (5) @(posedge clk);
    #1 check_flags();
  endtask

  task automatic sendr(input logic [7:0] b);
    send(b, $urandom_range(3, 6), 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.EVT_VALID && bus.RD_EN) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_event: got %h expected none",
                 {bus.EVT_BRK, bus.EVT_EXT, bus.EVT_CODE});
      end else begin
        mon_e = exp_q.pop_front();
        chk("event", {22'd0, bus.EVT_BRK, bus.EVT_EXT, bus.EVT_CODE}, {22'd0, mon_e});
        m_cnt--;
      end
    end
  end

  initial begin
    n_pass = 0; n_total = 0;
    bus.CODE = 8'h00; bus.NEW_CODE = 1'b0; bus.RD_EN = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_evt_valid", bus.EVT_VALID, 0);
    chk("rst_state", dbg_state, S_IDLE);
    check_flags();
    #1 rst_n = 1'b1;

    // First make: EVT_VALID low in the processing cycle, high one cycle later.
    @(posedge clk); #2;
    bus.CODE = 8'h1C; bus.NEW_CODE = 1'b1;
    model_byte(8'h1C, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("evt_valid_k1", bus.EVT_VALID, 0);
    @(posedge clk);
    #1 chk("evt_valid_k2", bus.EVT_VALID, 1);
    #1 bus.NEW_CODE = 1'b0;
    repeat (5) @(posedge clk);
    #1 check_flags();

    sendr(8'hF0); sendr(8'h1C);
    sendr(8'hE0); sendr(8'h75);
    sendr(8'hE0); sendr(8'hF0); sendr(8'h75);
    sendr(8'hE0); sendr(8'h14);
    sendr(8'hE0); sendr(8'hF0); sendr(8'h14);
    sendr(8'h12); sendr(8'h59); sendr(8'hF0); sendr(8'h12); sendr(8'hF0); sendr(8'h59);
    sendr(8'h58); sendr(8'h58); sendr(8'h58); sendr(8'hF0); sendr(8'h58); sendr(8'h58);
    sendr(8'hF0); sendr(8'h58);
    for (int i = 0; i < 8; i++) sendr(pause_seq[i]);
    sendr(8'h1C);
    sendr(8'hAA);

    // Fill the FIFO, then a same-cycle pop+write, then a true overflow.
    @(posedge clk); #2 bus.RD_EN = 1'b0;
    sendr(8'h1C); sendr(8'h32); sendr(8'h21); sendr(8'h23);
    send(8'h24, 6, 1'b1);
    sendr(8'h2B);
    chk("head_valid", bus.EVT_VALID, 1);
    chk("head_event", {22'd0, bus.EVT_BRK, bus.EVT_EXT, bus.EVT_CODE}, {22'd0, exp_q[0]});
    @(posedge clk); #2 bus.RD_EN = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("drained", exp_q.size(), 0);

    // Reset in the middle of an E0 sequence with Caps Lock on.
    sendr(8'h58); sendr(8'hF0); sendr(8'h58); sendr(8'h14); sendr(8'hE0);
    @(posedge clk); #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst2_evt_valid", bus.EVT_VALID, 0);
    chk("rst2_evt", {bus.EVT_BRK, bus.EVT_EXT, bus.EVT_CODE}, 0);
    chk("rst2_state", dbg_state, S_IDLE);
    check_flags();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    sendr(8'h75);
    send(8'h1C, 10, 1'b0);

    // Randomised traffic: well-formed key sequences mixed with raw bytes.
    for (int i = 0; i < 50; i++) begin
      int r = $urandom_range(0, 9);
      if (r <= 5) begin
        if ($urandom_range(0, 1) == 1) sendr(8'hE0);
        if ($urandom_range(0, 1) == 1) sendr(8'hF0);
        sendr(keys[$urandom_range(0, 9)]);
      end else if (r == 6) sendr(stats[$urandom_range(0, 5)]);
      else if (r == 7) begin
        for (int j = 0; j < 8; j++) sendr(pause_seq[j]);
      end else sendr(8'($urandom_range(0, 255)));
    end

    repeat (10) @(posedge clk);
    #1 chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
